// File: rtl/uart_rom_loader.sv
// uart_rom_loader: 8N1 UART receiver that loads a framed Chip-8 ROM image into CPU memory.
// Define UART_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte per frame.
module uart_rom_loader #(
    parameter int          CLKS_PER_BIT   = 217,
    parameter logic [11:0] BASE_ADDR      = 12'h200,
    parameter int          TIMEOUT_CYCLES = 2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    output logic        upload_en,
    output logic        upload_clk,
    output logic [7:0]  upload_data,
    output logic [11:0] upload_addr,
    output logic        done,
    output logic        error,
    output logic        busy
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   MAX_LEN   = 16'(4096 - int'(BASE_ADDR));
    localparam logic [7:0]    SYNC_BYTE = 8'hC8;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef UART_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_WAIT_WR
    } state_e;

    // ---------------- RX front end ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       rx_st_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_sh_q;
    logic [7:0]      rx_byte_q;
    logic            rx_valid_q;
    logic            rx_ferr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            case (rx_st_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_st_q  <= RX_START;
                        rx_cnt_q <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                        rx_bit_q <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= RX_IDLE;
                        if (rx_sync_q) begin
                            rx_byte_q  <= rx_sh_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            rx_ferr_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------- Frame / write FSM ----------------
    state_e        state_q;
    logic [7:0]    len_hi_q;
    logic [12:0]   rem_q;
    logic [1:0]    wr_ph_q;
    logic [TW-1:0] tmo_q;
    logic          pend_q;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]    sum_q;
`endif
    logic          upload_en_q, upload_clk_q, done_q, error_q;
    logic [7:0]    upload_data_q;
    logic [11:0]   upload_addr_q;

    logic          byte_ev_d;
    logic [15:0]   len_d;
    logic          tmo_hit_d;

    always_comb begin
        byte_ev_d = rx_valid_q | pend_q;
        len_d     = {len_hi_q, rx_byte_q};
        tmo_hit_d = (tmo_q == TO_LAST) && (state_q != S_IDLE) && (state_q != S_WAIT_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            len_hi_q      <= '0;
            rem_q         <= '0;
            wr_ph_q       <= '0;
            tmo_q         <= '0;
            pend_q        <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q         <= '0;
`endif
            upload_en_q   <= 1'b0;
            upload_clk_q  <= 1'b0;
            upload_data_q <= '0;
            upload_addr_q <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Timeout counts idle time between bytes; writes themselves never time out.
            if (rx_valid_q || state_q == S_IDLE || state_q == S_WAIT_WR) tmo_q <= '0;
            else                                                     tmo_q <= tmo_q + TW'(1);

            if (state_q != S_IDLE && (rx_ferr_q || tmo_hit_d)) begin
                error_q      <= 1'b1;
                upload_en_q  <= 1'b0;
                upload_clk_q <= 1'b0;
                pend_q       <= 1'b0;
                state_q      <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_valid_q && rx_byte_q == SYNC_BYTE) begin
                            error_q       <= 1'b0;
                            upload_en_q   <= 1'b1;
                            upload_addr_q <= BASE_ADDR;
`ifdef UART_LOADER_CHECKSUM_EN
                            sum_q         <= '0;
`endif
                            state_q       <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (rx_valid_q) begin
                            len_hi_q <= rx_byte_q;
                            state_q  <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        if (rx_valid_q) begin
                            if (len_d == 16'd0 || len_d > MAX_LEN) begin
                                error_q     <= 1'b1;
                                upload_en_q <= 1'b0;
                                state_q     <= S_IDLE;
                            end else begin
                                rem_q   <= 13'(len_d);
                                state_q <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (byte_ev_d) begin
                            pend_q        <= 1'b0;
                            upload_data_q <= rx_byte_q;
`ifdef UART_LOADER_CHECKSUM_EN
                            sum_q         <= sum_q + rx_byte_q;
`endif
                            wr_ph_q       <= 2'd0;
                            state_q       <= S_WAIT_WR;
                        end
                    end
                    S_WAIT_WR: begin
                        // rx_byte_q stays stable until the next stop bit, so only a flag is kept.
                        if (rx_valid_q) pend_q <= 1'b1;
                        case (wr_ph_q)
                            2'd0: begin
                                upload_clk_q <= 1'b1;
                                wr_ph_q      <= 2'd1;
                            end
                            2'd1: begin
                                upload_clk_q <= 1'b0;
                                wr_ph_q      <= 2'd2;
                            end
                            default: begin
                                upload_addr_q <= upload_addr_q + 12'd1;
                                rem_q         <= rem_q - 13'd1;
                                wr_ph_q       <= 2'd0;
                                if (rem_q == 13'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                    state_q <= S_CHECK;
`else
                                    done_q      <= 1'b1;
                                    upload_en_q <= 1'b0;
                                    state_q     <= S_IDLE;
`endif
                                end else begin
                                    state_q <= S_DATA;
                                end
                            end
                        endcase
                    end
`ifdef UART_LOADER_CHECKSUM_EN
                    S_CHECK: begin
                        if (byte_ev_d) begin
                            pend_q      <= 1'b0;
                            upload_en_q <= 1'b0;
                            state_q     <= S_IDLE;
                            if (rx_byte_q == sum_q) done_q  <= 1'b1;
                            else                    error_q <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        upload_en_q  <= 1'b0;
                        upload_clk_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign upload_en   = upload_en_q;
    assign upload_clk  = upload_clk_q;
    assign upload_data = upload_data_q;
    assign upload_addr = upload_addr_q;
    assign done        = done_q;
    assign error       = error_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed + randomized bench for uart_rom_loader; expected writes come from a byte-level frame model.
module tb_uart_rom_loader;
    localparam int          CPB  = 8;
    localparam int          TO   = 1000;
    localparam logic [11:0] BASE = 12'h200;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic        upload_en, upload_clk, done, error, busy;
    logic [7:0]  upload_data;
    logic [11:0] upload_addr;

    int checks = 0;
    int failures = 0;
    logic [19:0] wq[$];
    int done_cnt = 0;

    uart_rom_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd),
        .upload_en(upload_en), .upload_clk(upload_clk), .upload_data(upload_data),
        .upload_addr(upload_addr), .done(done), .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge upload_clk) wq.push_back({upload_addr, upload_data});
    always @(posedge clk) if (done) done_cnt++;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic uart_byte(input logic [7:0] b, input logic stop = 1'b1, input int gap = 4);
        rxd = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin rxd = b[i]; tick(CPB); end
        rxd = stop; tick(CPB);
        rxd = 1'b1; tick(gap);
    endtask

    // ck_delta != 0 corrupts the checksum byte (only sent when the checksum build is active).
    task automatic send_frame(input bq_t pl, input int ck_delta, input int gap);
        logic [7:0]  s;
        logic [15:0] n;
        n = 16'(pl.size());
        s = 8'(ck_delta);
        uart_byte(8'hC8, 1'b1, gap);
        uart_byte(n[15:8], 1'b1, gap);
        uart_byte(n[7:0], 1'b1, gap);
        foreach (pl[i]) begin
            uart_byte(pl[i], 1'b1, gap);
            s = s + pl[i];
        end
`ifdef UART_LOADER_CHECKSUM_EN
        uart_byte(s, 1'b1, gap);
`endif
    endtask

    // Model: the first n payload bytes land at BASE, BASE+1, ... in order.
    task automatic check_writes(input string tag, input int wb, input bq_t pl, input int n);
        chk({tag, "_nwr"}, 32'(wq.size() - wb), 32'(n));
        for (int i = 0; i < n; i++)
            if (wb + i < wq.size())
                chk({tag, "_wr"}, 32'(wq[wb + i]), 32'({BASE + 12'(i), pl[i]}));
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_en"},   32'(upload_en),   0);
        chk({tag, "_uclk"}, 32'(upload_clk),  0);
        chk({tag, "_data"}, 32'(upload_data), 0);
        chk({tag, "_addr"}, 32'(upload_addr), 0);
        chk({tag, "_done"}, 32'(done),        0);
        chk({tag, "_err"},  32'(error),       0);
        chk({tag, "_busy"}, 32'(busy),        0);
    endtask

    function automatic bq_t rand_payload(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t pl;
        int  wb, d0, ck_bad;
        logic [7:0] g;

        // Reset
        tick(3);
        check_reset_outs("reset");
        rst_n = 1'b1;
        tick(5);

        // Basic frame
        pl = '{8'h12, 8'h34, 8'h56};
        wb = wq.size(); d0 = done_cnt;
        send_frame(pl, 0, 4);
        tick(20);
        check_writes("basic", wb, pl, 3);
        chk("basic_done", 32'(done_cnt - d0), 1);
        chk("basic_err", 32'(error), 0);
        chk("basic_en", 32'(upload_en), 0);
        chk("basic_busy", 32'(busy), 0);

        // Garbage and a start-bit glitch before a frame
        wb = wq.size(); d0 = done_cnt;
        uart_byte(8'h00); uart_byte(8'hFF); uart_byte(8'h55);
        rxd = 1'b0; tick(2); rxd = 1'b1; tick(CPB * 12);
        chk("garb_nwr", 32'(wq.size() - wb), 0);
        chk("garb_err", 32'(error), 0);
        chk("garb_busy", 32'(busy), 0);
        pl = '{8'hAA};
        send_frame(pl, 0, 4);
        tick(20);
        check_writes("garb", wb, pl, 1);
        chk("garb_done", 32'(done_cnt - d0), 1);

        // Length bounds
        wb = wq.size(); d0 = done_cnt;
        uart_byte(8'hC8); uart_byte(8'h0E);
        chk("len_en_up", 32'(upload_en), 1);
        chk("len_busy", 32'(busy), 1);
        uart_byte(8'h01);
        chk("len_big_err", 32'(error), 1);
        chk("len_big_en", 32'(upload_en), 0);
        uart_byte(8'hC8);
        chk("len_sync_clr", 32'(error), 0);
        uart_byte(8'h00); uart_byte(8'h00);
        chk("len_zero_err", 32'(error), 1);
        chk("len_zero_busy", 32'(busy), 0);
        uart_byte(8'hC8); uart_byte(8'h0E); uart_byte(8'h00);
        chk("len_max_ok", 32'({error, upload_en, busy}), 32'b011);
        uart_byte(8'h77, 1'b0);
        chk("ferr_err", 32'(error), 1);
        chk("ferr_en", 32'(upload_en), 0);
        chk("len_nwr", 32'(wq.size() - wb), 0);
        chk("len_done", 32'(done_cnt - d0), 0);

        // Inter-byte timeout, then recovery
        pl = rand_payload(4);
        wb = wq.size();
        uart_byte(8'hC8); uart_byte(8'h00); uart_byte(8'h04);
        uart_byte(pl[0]); uart_byte(pl[1]);
        chk("to_pre_err", 32'(error), 0);
        tick(TO + 100);
        check_writes("to", wb, pl, 2);
        chk("to_err", 32'(error), 1);
        chk("to_en", 32'(upload_en), 0);
        pl = rand_payload(3);
        wb = wq.size(); d0 = done_cnt;
        send_frame(pl, 0, 4);
        tick(20);
        check_writes("to_rec", wb, pl, 3);
        chk("to_rec_err", 32'(error), 0);
        chk("to_rec_done", 32'(done_cnt - d0), 1);

        // Framing error in IDLE is ignored
        uart_byte(8'h33, 1'b0);
        tick(10);
        chk("idle_ferr_err", 32'(error), 0);
        chk("idle_ferr_busy", 32'(busy), 0);

`ifdef UART_LOADER_CHECKSUM_EN
        // Bad checksum: 01+02 = 03, 04 is sent
        pl = '{8'h01, 8'h02};
        wb = wq.size(); d0 = done_cnt;
        send_frame(pl, 1, 4);
        tick(20);
        check_writes("cks", wb, pl, 2);
        chk("cks_err", 32'(error), 1);
        chk("cks_done", 32'(done_cnt - d0), 0);
        chk("cks_en", 32'(upload_en), 0);
`endif

        // Reset during the 2nd payload byte
        pl = rand_payload(4);
        wb = wq.size();
        uart_byte(8'hC8); uart_byte(8'h00); uart_byte(8'h04); uart_byte(pl[0]);
        rxd = 1'b0; tick(CPB * 4);
        rst_n = 1'b0;
        tick(1);
        check_reset_outs("midrst");
        rxd = 1'b1; tick(3);
        rst_n = 1'b1;
        tick(CPB * 12);
        check_writes("midrst", wb, pl, 1);
        pl = rand_payload(2);
        wb = wq.size(); d0 = done_cnt;
        send_frame(pl, 0, 4);
        tick(20);
        check_writes("postrst", wb, pl, 2);
        chk("postrst_done", 32'(done_cnt - d0), 1);

        // Random frames with garbage prefixes and random gaps
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
                g = 8'($urandom);
                if (g == 8'hC8) g = 8'h00;
                uart_byte(g, 1'b1, int'($urandom_range(20, 1)));
            end
            pl = rand_payload(int'($urandom_range(6, 1)));
`ifdef UART_LOADER_CHECKSUM_EN
            ck_bad = int'($urandom_range(1, 0));
`else
            ck_bad = 0;
`endif
            wb = wq.size(); d0 = done_cnt;
            send_frame(pl, ck_bad, int'($urandom_range(30, 1)));
            tick(20);
            check_writes("rnd", wb, pl, pl.size());
            chk("rnd_done", 32'(done_cnt - d0), (ck_bad != 0) ? 0 : 1);
            chk("rnd_err", 32'(error), (ck_bad != 0) ? 1 : 0);
            chk("rnd_en", 32'(upload_en), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rom_loader.md
# uart_rom_loader

Serial program loader directly upstream of the `chip8` top's upload port. It receives a framed Chip-8 ROM image over a UART RX line (8N1) and writes each byte into CPU memory through `upload_en`/`upload_clk`/`upload_data`/`upload_addr`, starting at 0x200. `upload_en` holds the CPU halted for the whole transfer. It reports completion and errors to the board-level logic.

## Interface
- `CLKS_PER_BIT`, 217: clk cycles per UART bit (25 MHz / 115200); must be ≥ 8.
- `BASE_ADDR`, 12'h200: CPU address of the first payload byte.
- `TIMEOUT_CYCLES`, 2_500_000: idle cycles allowed between bytes inside a frame.
- `clk` input 1: single clock for all logic; `upload_clk` is generated in this domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `rxd` input 1: UART receive line, idle high, asynchronous to `clk`.
- `upload_en` output 1: high while a frame is being loaded.
- `upload_clk` output 1: write strobe to CPU memory. Rising edge commits `upload_data` to `upload_addr`.
- `upload_data` output 8: byte being written.
- `upload_addr` output 12: target address.
- `done` output 1: one-cycle pulse when a frame completes without error.
- `error` output 1: sticky error flag. Cleared when the next sync byte is accepted.
- `busy` output 1: high in any state other than IDLE.

## Operation
- RX front end:
  - `rxd` passes through a 2-flop synchronizer.
  - A falling edge in idle starts a byte. The start bit is re-checked at CLKS_PER_BIT/2; if it reads high, the byte is discarded silently.
  - 8 data bits are sampled LSB first, one every CLKS_PER_BIT, at mid-bit.
  - Stop bit = 0 is a framing error.
  - A valid byte produces a one-cycle internal `rx_valid`.
- Frame format: sync 0xC8, LEN_HI, LEN_LO, LEN payload bytes, then an optional checksum (see Configuration).
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHECK, WAIT_WR.
  - IDLE: bytes other than 0xC8 are ignored. On 0xC8: go to LEN_HI, clear `error`, set `upload_en`, load `upload_addr` = BASE_ADDR.
  - LEN_HI → LEN_LO: latch the upper length byte.
  - LEN_LO: latch the 16-bit LEN.
    - If LEN = 0 or LEN > 4096 − BASE_ADDR (3584 at default): set `error`, go to IDLE.
    - Otherwise go to DATA with remaining = LEN.
  - DATA: on `rx_valid`, drive `upload_data` = byte and go to WAIT_WR.
  - WAIT_WR: hold `upload_clk` = 1 for one cycle, then 0 for one cycle. Then increment `upload_addr` (12-bit) and decrement remaining.
    - remaining = 0: go to CHECK (macro defined) or finish.
    - Otherwise return to DATA.
  - Finish: pulse `done`, drop `upload_en` in the same cycle, go to IDLE.
- Abort conditions, all of which set `error`, drop `upload_en` and go to IDLE:
  - framing error in any non-IDLE state;
  - no `rx_valid` for TIMEOUT_CYCLES in LEN_HI, LEN_LO, DATA or CHECK.
  - A framing error in IDLE is ignored.
- Bytes already written before an abort stay in memory.
- Bytes arriving during WAIT_WR are accepted, because WAIT_WR (3 cycles) is much shorter than one byte time.

## Timing
- Reset values: `upload_en`=0, `upload_clk`=0, `upload_data`=0, `upload_addr`=0, `done`=0, `error`=0, `busy`=0. FSM = IDLE, RX idle.
- `rxd` falling edge to `rx_valid`: 2 sync cycles + ~9.5 × CLKS_PER_BIT.
- Write sequence after `rx_valid` in DATA:
  - cycle +1: `upload_data`/`upload_addr` valid;
  - cycle +2: `upload_clk` rises;
  - cycle +3: `upload_clk` falls;
  - cycle +4: address increments.
- Data and address are stable for ≥1 cycle on each side of the `upload_clk` rising edge.
- `upload_en` rises the cycle after the sync byte's `rx_valid`. It falls the cycle after the final `upload_clk` low phase (or after CHECK), coincident with `done`.
- `rst_n` low mid-frame: all outputs return to reset values immediately. No further writes are issued.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined:
  - after the payload, one checksum byte is expected, equal to the 8-bit sum of all payload bytes mod 256;
  - CHECK compares; on mismatch, set `error` with no `done`;
  - `upload_en` drops in either case.
- Undefined: CHECK state and the checksum accumulator are absent. The frame ends after the last payload write.

## Test plan
- Frame C8 00 03 12 34 56 (+ checksum 9C if the macro is defined) → writes 12@200, 34@201, 56@202. `done` pulses once, `error`=0, `upload_en` low afterwards.
- Garbage bytes 00 FF 55 before C8 00 01 AA (+AA) → only AA@200 is written. The garbage causes no writes and no error.
- LEN = 0x0E01 (C8 0E 01) → `error`=1, no `upload_clk` edges, `upload_en`=0 on the next cycle.
- C8 00 04 then 2 bytes, then silence > TIMEOUT_CYCLES → 2 writes, then `error`=1, `upload_en`=0. A following valid frame clears `error`.
- Macro defined: C8 00 02 01 02 with checksum 04 → `error`=1, no `done`, bytes still at 200/201.
- `rst_n` pulsed low during the 2nd payload byte of a 4-byte frame → outputs at reset values. The 2nd byte is not written, and the next C8 frame loads normally.
